// File: rtl/dmem_arbiter.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | dmem_arbiter: round-robin arbiter for the shared data memory, with       |
// | bounded locked sequences for atomic read-modify-write.                   |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module dmem_arbiter #(
  parameter int AW       = 32,
  parameter int DW       = 32,
  parameter int MAX_LOCK = 4
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          m0_req,
  input  logic          m1_req,
  input  logic          m0_we,
  input  logic          m1_we,
  input  logic          m0_lock,
  input  logic          m1_lock,
  input  logic [AW-1:0] m0_addr,
  input  logic [AW-1:0] m1_addr,
  input  logic [DW-1:0] m0_wdata,
  input  logic [DW-1:0] m1_wdata,
  output logic          m0_gnt,
  output logic          m1_gnt,
  output logic          m0_rvalid,
  output logic          m1_rvalid,
  output logic [DW-1:0] m0_rdata,
  output logic [DW-1:0] m1_rdata,
  output logic          mem_en,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata,
  output logic [15:0]   m0_wait_cnt
);

  localparam int            CW         = $clog2(MAX_LOCK + 1);
  localparam logic [CW-1:0] C_MAX_LOCK = CW'(MAX_LOCK);
  localparam logic [CW-1:0] C_ONE      = CW'(1);

  localparam logic [1:0] S_UNLOCKED = 2'd0;
  localparam logic [1:0] S_LOCK0    = 2'd1;
  localparam logic [1:0] S_LOCK1    = 2'd2;

  logic [1:0]    r_mode;
  logic          r_last;
  logic [CW-1:0] r_lock_cnt;
  logic          r_m0_rvalid;
  logic          r_m1_rvalid;
  logic [15:0]   r_wait_cnt;

  logic [1:0]    w_mode;
  logic          w_last;
  logic [CW-1:0] w_cnt;
  logic          w_held;
  logic          w_owner;
  logic          w_gnt0;
  logic          w_gnt1;
  logic [1:0]    w_mode_nxt;
  logic          w_last_nxt;
  logic [CW-1:0] w_cnt_nxt;

  // During the reset cycle the combinational outputs see the reset state.
  assign w_mode  = reset ? S_UNLOCKED : r_mode;
  assign w_last  = reset ? 1'b1 : r_last;
  assign w_cnt   = reset ? '0 : r_lock_cnt;
  assign w_held  = (w_mode != S_UNLOCKED) && (w_cnt < C_MAX_LOCK);
  assign w_owner = (w_mode == S_LOCK1);

  always_comb begin
    w_gnt0 = 1'b0;
    w_gnt1 = 1'b0;
    if (w_held) begin
      w_gnt0 = ~w_owner & m0_req;
      w_gnt1 = w_owner & m1_req;
    end else begin
      w_gnt0 = m0_req & (~m1_req | w_last);
      w_gnt1 = m1_req & (~m0_req | ~w_last);
    end
  end

  // A lock continues only while held and re-requested; a forced release restarts at 1.
  always_comb begin
    w_mode_nxt = S_UNLOCKED;
    w_cnt_nxt  = '0;
    w_last_nxt = w_last;
    if (w_gnt0) begin
      w_last_nxt = 1'b0;
      if (m0_lock) begin
        w_mode_nxt = S_LOCK0;
        w_cnt_nxt  = w_held ? (w_cnt + C_ONE) : C_ONE;
      end
    end else if (w_gnt1) begin
      w_last_nxt = 1'b1;
      if (m1_lock) begin
        w_mode_nxt = S_LOCK1;
        w_cnt_nxt  = w_held ? (w_cnt + C_ONE) : C_ONE;
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_mode      <= S_UNLOCKED;
      r_last      <= 1'b1;
      r_lock_cnt  <= '0;
      r_m0_rvalid <= 1'b0;
      r_m1_rvalid <= 1'b0;
      r_wait_cnt  <= 16'd0;
    end else begin
      r_mode      <= w_mode_nxt;
      r_last      <= w_last_nxt;
      r_lock_cnt  <= w_cnt_nxt;
      r_m0_rvalid <= w_gnt0 & ~m0_we;
      r_m1_rvalid <= w_gnt1 & ~m1_we;
      if (m0_req && !w_gnt0 && (r_wait_cnt != 16'hFFFF)) begin
        r_wait_cnt <= r_wait_cnt + 16'd1;
      end
    end
  end

  assign m0_gnt      = w_gnt0;
  assign m1_gnt      = w_gnt1;
  assign m0_rvalid   = r_m0_rvalid & ~reset;
  assign m1_rvalid   = r_m1_rvalid & ~reset;
  assign m0_rdata    = m0_rvalid ? mem_rdata : '0;
  assign m1_rdata    = m1_rvalid ? mem_rdata : '0;
  assign m0_wait_cnt = reset ? 16'd0 : r_wait_cnt;

  assign mem_en    = w_gnt0 | w_gnt1;
  assign mem_we    = w_gnt0 ? m0_we    : (w_gnt1 ? m1_we    : 1'b0);
  assign mem_addr  = w_gnt0 ? m0_addr  : (w_gnt1 ? m1_addr  : '0);
  assign mem_wdata = w_gnt0 ? m0_wdata : (w_gnt1 ? m1_wdata : '0);

endmodule
`default_nettype wire

// File: tb/tb_dmem_arbiter.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_dmem_arbiter: bench for dmem_arbiter with a rule-level reference model |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module tb_dmem_arbiter;
  localparam int AW       = 32;
  localparam int DW       = 32;
  localparam int MAX_LOCK = 4;
  localparam int SAT_LOCK = 64;

  logic clock = 1'b0;
  always #5 clock = ~clock;

  logic          reset;
  logic [1:0]    s_req, s_we, s_lock;
  logic [AW-1:0] s_addr  [2];
  logic [DW-1:0] s_wdata [2];

  logic          m0_gnt, m1_gnt, m0_rvalid, m1_rvalid;
  logic [DW-1:0] m0_rdata, m1_rdata;
  logic          mem_en, mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata, mem_rdata;
  logic [15:0]   m0_wait_cnt;

  dmem_arbiter #(.AW(AW), .DW(DW), .MAX_LOCK(MAX_LOCK)) dut (
    .clock(clock), .reset(reset),
    .m0_req(s_req[0]), .m1_req(s_req[1]),
    .m0_we(s_we[0]), .m1_we(s_we[1]),
    .m0_lock(s_lock[0]), .m1_lock(s_lock[1]),
    .m0_addr(s_addr[0]), .m1_addr(s_addr[1]),
    .m0_wdata(s_wdata[0]), .m1_wdata(s_wdata[1]),
    .m0_gnt(m0_gnt), .m1_gnt(m1_gnt),
    .m0_rvalid(m0_rvalid), .m1_rvalid(m1_rvalid),
    .m0_rdata(m0_rdata), .m1_rdata(m1_rdata),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
    .m0_wait_cnt(m0_wait_cnt)
  );

  // Second instance with a long lock bound so m0 waits almost every cycle.
  logic          sat_rst, sat_req0, sat_req1, sat_lock1;
  logic          sat_gnt0, sat_gnt1, sat_rv0, sat_rv1, sat_en, sat_we;
  logic [DW-1:0] sat_rd0, sat_rd1, sat_wdata;
  logic [AW-1:0] sat_addr;
  logic [15:0]   sat_wait;

  dmem_arbiter #(.AW(AW), .DW(DW), .MAX_LOCK(SAT_LOCK)) dut_sat (
    .clock(clock), .reset(sat_rst),
    .m0_req(sat_req0), .m1_req(sat_req1),
    .m0_we(1'b0), .m1_we(1'b0),
    .m0_lock(1'b0), .m1_lock(sat_lock1),
    .m0_addr(32'h4), .m1_addr(32'h8),
    .m0_wdata(32'h0), .m1_wdata(32'h0),
    .m0_gnt(sat_gnt0), .m1_gnt(sat_gnt1),
    .m0_rvalid(sat_rv0), .m1_rvalid(sat_rv1),
    .m0_rdata(sat_rd0), .m1_rdata(sat_rd1),
    .mem_en(sat_en), .mem_we(sat_we), .mem_addr(sat_addr),
    .mem_wdata(sat_wdata), .mem_rdata(32'h0),
    .m0_wait_cnt(sat_wait)
  );

  // Behavioural single-port memory behind the main instance.
  logic          sram_clr;
  logic [DW-1:0] sram [256];
  logic [DW-1:0] sram_q;
  always @(posedge clock) begin
    if (sram_clr) begin
      for (int i = 0; i < 256; i++) sram[i] <= '0;
    end else if (mem_en) begin
      if (mem_we) sram[mem_addr[7:0]] <= mem_wdata;
      else        sram_q <= sram[mem_addr[7:0]];
    end
  end
  assign mem_rdata = sram_q;

  int n_checks = 0;
  int n_errors = 0;

  // Reference model: lock owner (-1 = none), grants in current run, last winner.
  int            md_owner, md_run, md_last, md_wait;
  bit            md_rv [2];
  logic [DW-1:0] md_rd [2];
  logic [DW-1:0] mmem  [256];

  int            e_g, n_owner, n_run, n_last;
  logic          e_en, e_we, e_rv0, e_rv1;
  logic [AW-1:0] e_addr;
  logic [DW-1:0] e_wdata, e_rd0, e_rd1;
  logic [15:0]   e_wait;

  task automatic settle();
    int  owner, run, last;
    bit  forced;
    #2;
    owner  = reset ? -1 : md_owner;
    run    = reset ? 0  : md_run;
    last   = reset ? 1  : md_last;
    forced = (owner >= 0) && (run == MAX_LOCK);
    e_g    = -1;
    if (owner >= 0 && !forced) begin
      if (s_req[owner]) e_g = owner;
    end else if (s_req == 2'b11) e_g = 1 - last;
    else if (s_req[0])          e_g = 0;
    else if (s_req[1])          e_g = 1;
    n_last = (e_g >= 0) ? e_g : last;
    if (e_g >= 0 && s_lock[e_g]) begin
      n_owner = e_g;
      n_run   = (owner == e_g && !forced) ? run + 1 : 1;
    end else begin
      n_owner = -1;
      n_run   = 0;
    end
    if (e_g >= 0) begin
      e_en = 1'b1; e_we = s_we[e_g]; e_addr = s_addr[e_g]; e_wdata = s_wdata[e_g];
    end else begin
      e_en = 1'b0; e_we = 1'b0; e_addr = '0; e_wdata = '0;
    end
    e_rv0  = !reset && md_rv[0];
    e_rv1  = !reset && md_rv[1];
    e_rd0  = e_rv0 ? md_rd[0] : '0;
    e_rd1  = e_rv1 ? md_rd[1] : '0;
    e_wait = reset ? 16'd0 : 16'(md_wait);
  endtask

  task automatic commit();
    @(posedge clock);
    for (int k = 0; k < 2; k++) begin
      md_rv[k] = !reset && (e_g == k) && !s_we[k];
      if (e_g == k && !s_we[k]) md_rd[k] = mmem[s_addr[k][7:0]];
    end
    if (e_g >= 0 && s_we[e_g]) mmem[s_addr[e_g][7:0]] = s_wdata[e_g];
    if (reset) begin
      md_owner = -1; md_run = 0; md_last = 1; md_wait = 0;
    end else begin
      if (s_req[0] && e_g != 0 && md_wait < 65535) md_wait++;
      md_owner = n_owner; md_run = n_run; md_last = n_last;
    end
    @(negedge clock);
  endtask

  task automatic do_reset();
    reset = 1'b1; s_req = 2'b00; s_lock = 2'b00;
    settle(); commit();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1; s_req = 2'b00;
    settle();
    n_checks += 4;
    if ({m0_gnt, m1_gnt} !== 2'b00) begin n_errors++; $display("FAIL reset_gnt got %b exp 00", {m0_gnt, m1_gnt}); end
    if (mem_en !== 1'b0) begin n_errors++; $display("FAIL reset_mem_en got %b exp 0", mem_en); end
    if ({m0_rvalid, m1_rvalid} !== 2'b00) begin n_errors++; $display("FAIL reset_rvalid got %b exp 00", {m0_rvalid, m1_rvalid}); end
    if (m0_wait_cnt !== 16'd0) begin n_errors++; $display("FAIL reset_wait got %h exp 0", m0_wait_cnt); end
    commit();
    reset = 1'b0;
  endtask

  task automatic test_round_robin();
    s_req = 2'b11; s_we = 2'b00; s_lock = 2'b00;
    s_addr[0] = 32'h10; s_addr[1] = 32'h20;
    for (int i = 0; i < 4; i++) begin
      logic          x0;
      logic [AW-1:0] xa;
      x0 = (i % 2 == 0);
      xa = x0 ? 32'h10 : 32'h20;
      settle();
      n_checks += 4;
      if (m0_gnt !== x0) begin n_errors++; $display("FAIL rr_gnt0 cyc %0d got %b exp %b", i, m0_gnt, x0); end
      if (m1_gnt !== !x0) begin n_errors++; $display("FAIL rr_gnt1 cyc %0d got %b exp %b", i, m1_gnt, !x0); end
      if (mem_addr !== xa) begin n_errors++; $display("FAIL rr_addr cyc %0d got %h exp %h", i, mem_addr, xa); end
      if ({m1_rvalid, m0_rvalid} !== ((i == 0) ? 2'b00 : (x0 ? 2'b10 : 2'b01))) begin
        n_errors++; $display("FAIL rr_rvalid cyc %0d got %b", i, {m1_rvalid, m0_rvalid});
      end
      commit();
    end
    s_req = 2'b00;
    settle();
    n_checks += 2;
    if ({m1_rvalid, m0_rvalid} !== 2'b10) begin n_errors++; $display("FAIL rr_last_rvalid got %b exp 10", {m1_rvalid, m0_rvalid}); end
    if (m0_wait_cnt !== 16'd2) begin n_errors++; $display("FAIL rr_wait got %0d exp 2", m0_wait_cnt); end
    commit();
  endtask

  task automatic test_write_read();
    s_req = 2'b10; s_we = 2'b10; s_addr[1] = 32'h08; s_wdata[1] = 32'hDEADBEEF;
    settle();
    n_checks += 3;
    if (m1_gnt !== 1'b1) begin n_errors++; $display("FAIL wr_gnt1 got %b exp 1", m1_gnt); end
    if (mem_we !== 1'b1) begin n_errors++; $display("FAIL wr_mem_we got %b exp 1", mem_we); end
    if (mem_wdata !== 32'hDEADBEEF) begin n_errors++; $display("FAIL wr_wdata got %h exp deadbeef", mem_wdata); end
    commit();
    s_req = 2'b01; s_we = 2'b00; s_addr[0] = 32'h08;
    settle();
    n_checks += 2;
    if (m0_gnt !== 1'b1) begin n_errors++; $display("FAIL rd_gnt0 got %b exp 1", m0_gnt); end
    if (m1_rvalid !== 1'b0) begin n_errors++; $display("FAIL wr_no_rvalid got %b exp 0", m1_rvalid); end
    commit();
    s_req = 2'b00;
    settle();
    n_checks += 2;
    if (m0_rvalid !== 1'b1) begin n_errors++; $display("FAIL rd_rvalid got %b exp 1", m0_rvalid); end
    if (m0_rdata !== 32'hDEADBEEF) begin n_errors++; $display("FAIL rd_rdata got %h exp deadbeef", m0_rdata); end
    commit();
  endtask

  task automatic test_lock_forced();
    logic [5:0] seq0;
    seq0 = 6'b101111;  // bit i: m0 expected winner in cycle i
    do_reset();
    s_req = 2'b11; s_lock = 2'b01; s_we = 2'b00;
    s_addr[0] = 32'h40; s_addr[1] = 32'h44;
    for (int i = 0; i < 6; i++) begin
      settle();
      n_checks += 2;
      if (m0_gnt !== seq0[i]) begin n_errors++; $display("FAIL lock_gnt0 cyc %0d got %b exp %b", i, m0_gnt, seq0[i]); end
      if (m1_gnt !== !seq0[i]) begin n_errors++; $display("FAIL lock_gnt1 cyc %0d got %b exp %b", i, m1_gnt, !seq0[i]); end
      commit();
    end
    s_req = 2'b00; s_lock = 2'b00;
    settle(); commit();
  endtask

  task automatic test_lock_release();
    logic [3:0] seq1;
    seq1 = 4'b1011;  // bit i: m1 expected winner in cycle i
    for (int i = 0; i < 4; i++) begin
      case (i)
        0: begin s_req = 2'b11; s_lock = 2'b10; s_we = 2'b00; s_addr[1] = 32'h30; s_addr[0] = 32'h50; end
        1: begin s_lock = 2'b00; s_we = 2'b10; s_wdata[1] = 32'h1234_5678; end
        2: begin s_req = 2'b01; s_we = 2'b00; end
        default: begin s_req = 2'b11; end
      endcase
      settle();
      n_checks += 2;
      if (m1_gnt !== seq1[i]) begin n_errors++; $display("FAIL rel_gnt1 cyc %0d got %b exp %b", i, m1_gnt, seq1[i]); end
      if (m0_gnt !== !seq1[i]) begin n_errors++; $display("FAIL rel_gnt0 cyc %0d got %b exp %b", i, m0_gnt, !seq1[i]); end
      if (i == 1 || i == 2) begin
        n_checks++;
        if (m1_rvalid !== (i == 1)) begin n_errors++; $display("FAIL rel_rvalid cyc %0d got %b", i, m1_rvalid); end
      end
      commit();
    end
    s_req = 2'b00;
    settle(); commit();
  endtask

  task automatic test_reset_abandon();
    s_req = 2'b01; s_lock = 2'b01; s_we = 2'b00; s_addr[0] = 32'h10;
    settle();
    n_checks++;
    if (m0_gnt !== 1'b1) begin n_errors++; $display("FAIL ra_gnt0 got %b exp 1", m0_gnt); end
    commit();
    reset = 1'b1; s_req = 2'b00; s_lock = 2'b00;
    settle();
    n_checks += 2;
    if (m0_rvalid !== 1'b0) begin n_errors++; $display("FAIL ra_rvalid_in_reset got %b exp 0", m0_rvalid); end
    if (m0_wait_cnt !== 16'd0) begin n_errors++; $display("FAIL ra_wait_in_reset got %h exp 0", m0_wait_cnt); end
    commit();
    reset = 1'b0; s_req = 2'b11;
    settle();
    n_checks += 3;
    if ({m1_gnt, m0_gnt} !== 2'b01) begin n_errors++; $display("FAIL ra_first_gnt got %b exp 01", {m1_gnt, m0_gnt}); end
    if (m0_rvalid !== 1'b0) begin n_errors++; $display("FAIL ra_rvalid got %b exp 0", m0_rvalid); end
    if (m0_wait_cnt !== 16'd0) begin n_errors++; $display("FAIL ra_wait got %h exp 0", m0_wait_cnt); end
    commit();
    s_req = 2'b00;
    settle(); commit();
  endtask

  task automatic test_random();
    bit hold [2];
    int err0;
    hold = '{0, 0};
    err0 = n_errors;
    for (int c = 0; c < 3000 && (n_errors - err0) < 20; c++) begin
      for (int k = 0; k < 2; k++) begin
        if (!hold[k]) begin
          s_req[k]   = ($urandom_range(0, 9) < 7);
          s_we[k]    = $urandom_range(0, 1) == 1;
          s_lock[k]  = ($urandom_range(0, 9) < 4);
          s_addr[k]  = $urandom_range(0, 31);
          s_wdata[k] = $urandom;
        end
      end
      settle();
      n_checks += 11;
      if (m0_gnt !== (e_g == 0)) begin n_errors++; $display("FAIL rnd_gnt0 cyc %0d got %b exp %b", c, m0_gnt, e_g == 0); end
      if (m1_gnt !== (e_g == 1)) begin n_errors++; $display("FAIL rnd_gnt1 cyc %0d got %b exp %b", c, m1_gnt, e_g == 1); end
      if ((m0_gnt & m1_gnt) !== 1'b0) begin n_errors++; $display("FAIL rnd_onehot cyc %0d got %b%b exp not 11", c, m1_gnt, m0_gnt); end
      if (mem_en !== e_en) begin n_errors++; $display("FAIL rnd_en cyc %0d got %b exp %b", c, mem_en, e_en); end
      if (mem_we !== e_we) begin n_errors++; $display("FAIL rnd_we cyc %0d got %b exp %b", c, mem_we, e_we); end
      if (mem_addr !== e_addr) begin n_errors++; $display("FAIL rnd_addr cyc %0d got %h exp %h", c, mem_addr, e_addr); end
      if (mem_wdata !== e_wdata) begin n_errors++; $display("FAIL rnd_wdata cyc %0d got %h exp %h", c, mem_wdata, e_wdata); end
      if ({m1_rvalid, m0_rvalid} !== {e_rv1, e_rv0}) begin n_errors++; $display("FAIL rnd_rvalid cyc %0d got %b%b exp %b%b", c, m1_rvalid, m0_rvalid, e_rv1, e_rv0); end
      if (m0_rdata !== e_rd0) begin n_errors++; $display("FAIL rnd_rdata0 cyc %0d got %h exp %h", c, m0_rdata, e_rd0); end
      if (m1_rdata !== e_rd1) begin n_errors++; $display("FAIL rnd_rdata1 cyc %0d got %h exp %h", c, m1_rdata, e_rd1); end
      if (m0_wait_cnt !== e_wait) begin n_errors++; $display("FAIL rnd_wait cyc %0d got %0d exp %0d", c, m0_wait_cnt, e_wait); end
      for (int k = 0; k < 2; k++) hold[k] = s_req[k] && (e_g != k);
      commit();
    end
    s_req = 2'b00; s_lock = 2'b00;
    settle(); commit();
  endtask

  // m1 relocks continuously: m0 wins once every SAT_LOCK+1 cycles.
  task automatic test_saturation();
    int w, err0;
    logic g0;
    sat_rst = 1'b1;
    @(posedge clock); @(negedge clock);
    sat_rst = 1'b0; sat_req0 = 1'b1; sat_req1 = 1'b1; sat_lock1 = 1'b1;
    w = 0;
    err0 = n_errors;
    for (int t = 0; t < 68000 && (n_errors - err0) < 20; t++) begin
      #2;
      g0 = ((t % (SAT_LOCK + 1)) == 0);
      n_checks += 3;
      if (sat_gnt0 !== g0) begin n_errors++; $display("FAIL sat_gnt0 cyc %0d got %b exp %b", t, sat_gnt0, g0); end
      if (sat_gnt1 !== !g0) begin n_errors++; $display("FAIL sat_gnt1 cyc %0d got %b exp %b", t, sat_gnt1, !g0); end
      if (sat_wait !== 16'(w)) begin n_errors++; $display("FAIL sat_wait cyc %0d got %0d exp %0d", t, sat_wait, w); end
      if (!g0 && w < 65535) w++;
      @(negedge clock);
    end
    #2;
    n_checks++;
    if (sat_wait !== 16'hFFFF) begin n_errors++; $display("FAIL sat_final got %h exp ffff", sat_wait); end
    sat_req0 = 1'b0; sat_req1 = 1'b0; sat_lock1 = 1'b0;
  endtask

  initial begin
    reset = 1'b1; sram_clr = 1'b1;
    s_req = '0; s_we = '0; s_lock = '0;
    s_addr[0] = '0; s_addr[1] = '0; s_wdata[0] = '0; s_wdata[1] = '0;
    sat_rst = 1'b1; sat_req0 = 1'b0; sat_req1 = 1'b0; sat_lock1 = 1'b0;
    for (int i = 0; i < 256; i++) mmem[i] = '0;
    md_owner = -1; md_run = 0; md_last = 1; md_wait = 0;
    md_rv[0] = 1'b0; md_rv[1] = 1'b0; md_rd[0] = '0; md_rd[1] = '0;
    @(negedge clock);
    sram_clr = 1'b0;
    test_reset();
    test_round_robin();
    test_write_read();
    test_lock_forced();
    test_lock_release();
    test_reset_abandon();
    test_random();
    test_saturation();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
